// File: rtl/divider_pkg.sv
// Shared types and sizing helpers for the sequential restoring divider.
// Imported by the step datapath and the top-level controller.
package divider_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        CALC = 1'b1
    } state_t;

    localparam int DEF_WIDTH = 16;
    localparam int CNT_W     = $clog2(DEF_WIDTH + 1);

    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/divider_step.sv
// One restoring shift-subtract step: shift in the next dividend bit,
// try the subtraction, keep it only if it did not go negative.
module divider_step
    import divider_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH:0]   rem,
    input  logic [WIDTH-1:0] qsr,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   rem_next,
    output logic [WIDTH-1:0] qsr_next
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;
    logic           take;

    always_comb begin
        shifted  = {rem[WIDTH-1:0], qsr[WIDTH-1]};
        trial    = shifted - {1'b0, divisor};
        // A set top bit means the true shifted value already exceeds any divisor.
        take     = rem[WIDTH] | ~trial[WIDTH];
        rem_next = take ? trial : shifted;
        qsr_next = {qsr[WIDTH-2:0], take};
    end

endmodule

// File: rtl/divider_16_bit_seq.sv
// Iterative unsigned restoring divider with start/busy/done handshake.
// Produces quotient and remainder WIDTH cycles after an accepted start.
module divider_16_bit_seq
    import divider_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = cnt_width(WIDTH);

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH:0]   rem;
    logic [WIDTH-1:0] qsr;
    logic [WIDTH-1:0] dvsr;
    logic [WIDTH:0]   rem_next;
    logic [WIDTH-1:0] qsr_next;
    logic             last;

    divider_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem      (rem),
        .qsr      (qsr),
        .divisor  (dvsr),
        .rem_next (rem_next),
        .qsr_next (qsr_next)
    );

    assign last = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            rem         <= '0;
            qsr         <= '0;
            dvsr        <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        if (divisor == '0) begin
                            // Zero divisor resolves at once without entering CALC.
                            done        <= 1'b1;
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                        end else begin
                            rem         <= '0;
                            qsr         <= dividend;
                            dvsr        <= divisor;
                            cnt         <= '0;
                            busy        <= 1'b1;
                            div_by_zero <= 1'b0;
                            state       <= CALC;
                        end
                    end
                end
                CALC: begin
                    rem <= rem_next;
                    qsr <= qsr_next;
                    cnt <= cnt + 1'b1;
                    if (last) begin
                        quotient  <= qsr_next;
                        remainder <= rem_next[WIDTH-1:0];
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_divider_16_bit_seq.sv
// Directed and random checks of the sequential divider.
// Expected results are queued at start and compared on each done pulse.
module tb_divider_16_bit_seq;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass = 0;

    divider_16_bit_seq #(
        .WIDTH (W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
    endtask

    task automatic push_exp(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        e.a = a;
        e.b = b;
        if (b == '0) begin
            e.q  = '1;
            e.r  = a;
            e.dz = 1'b1;
        end else begin
            e.q  = a / b;
            e.r  = a % b;
            e.dz = 1'b0;
        end
        sb.push_back(e);
    endtask

    // Called at a negedge; returns at the first negedge after the accept edge.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
        check("idle_before_start", busy, 0);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        push_exp(a, b);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            if (done) begin
                lat = k;
                return;
            end
            @(negedge clk);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && done) begin
            check("busy_low_at_done", busy, 0);
            if (sb.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                e = sb.pop_front();
                check("quotient", quotient, e.q);
                check("remainder", remainder, e.r);
                check("div_by_zero", div_by_zero, e.dz);
                if (!e.dz) begin
                    check("invariant",
                          32'(quotient) * 32'(e.b) + 32'(remainder),
                          32'(e.a));
                    check("rem_lt_divisor", remainder < e.b, 1);
                end
            end
        end
    end

    initial begin
        int lat;
        int bc;
        int nd;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_quotient", quotient, 0);
        check("rst_remainder", remainder, 0);
        check("rst_dz", div_by_zero, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // 100 / 7 with latency and busy-width measurement
        issue(16'd100, 16'd7);
        lat = -1;
        bc = 0;
        for (int k = 1; k <= 30; k++) begin
            if (done) begin
                lat = k;
                break;
            end
            bc += int'(busy);
            @(negedge clk);
        end
        check("lat_100_7", lat, 17);
        check("busy_cycles", bc, 16);
        check("q_100_7", quotient, 14);
        check("r_100_7", remainder, 2);
        check("dz_100_7", div_by_zero, 0);
        repeat (3) @(negedge clk);
        check("hold_done_low", done, 0);
        check("hold_quotient", quotient, 14);

        // extremes and dividend < divisor
        issue(16'hFFFF, 16'd1);
        wait_done(lat);
        check("lat_ffff_1", lat, 17);
        check("q_ffff_1", quotient, 16'hFFFF);
        check("r_ffff_1", remainder, 0);
        issue(16'd3, 16'd10);
        wait_done(lat);
        check("q_3_10", quotient, 0);
        check("r_3_10", remainder, 3);

        // divide by zero resolves in one cycle, flag then clears
        @(negedge clk);
        issue(16'd5, 16'd0);
        check("dz_done", done, 1);
        check("dz_busy", busy, 0);
        check("dz_quotient", quotient, 16'hFFFF);
        check("dz_remainder", remainder, 5);
        check("dz_flag", div_by_zero, 1);
        @(negedge clk);
        check("dz_done_pulse", done, 0);
        issue(16'd9, 16'd3);
        check("dz_cleared", div_by_zero, 0);
        check("busy_9_3", busy, 1);
        check("q_held_during_calc", quotient, 16'hFFFF);
        wait_done(lat);
        check("q_9_3", quotient, 3);
        check("r_9_3", remainder, 0);

        // start while busy is ignored
        issue(16'd100, 16'd7);
        repeat (3) @(negedge clk);
        dividend = 16'd50;
        divisor  = 16'd5;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(lat);
        check("ign_q", quotient, 14);
        check("ign_r", remainder, 2);
        nd = 0;
        repeat (25) begin
            @(negedge clk);
            nd += int'(done);
        end
        check("ign_extra_done", nd, 0);

        // back-to-back: start held across the done cycle
        issue(16'd100, 16'd7);
        repeat (15) @(negedge clk);
        check("b2b_busy_before", busy, 1);
        dividend = 16'd1000;
        divisor  = 16'd33;
        start    = 1'b1;
        @(negedge clk);
        check("b2b_first_done", done, 1);
        check("b2b_first_q", quotient, 14);
        push_exp(16'd1000, 16'd33);
        @(negedge clk);
        start = 1'b0;
        check("b2b_second_busy", busy, 1);
        wait_done(lat);
        check("lat_b2b", lat, 17);
        check("b2b_q", quotient, 30);
        check("b2b_r", remainder, 10);

        // asynchronous reset mid-calculation
        issue(16'd1000, 16'd33);
        repeat (7) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_quotient", quotient, 0);
        check("arst_remainder", remainder, 0);
        check("arst_dz", div_by_zero, 0);
        sb.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        nd = 0;
        repeat (25) begin
            @(negedge clk);
            nd += int'(done);
        end
        check("arst_no_done", nd, 0);
        issue(16'd1000, 16'd33);
        wait_done(lat);
        check("lat_after_rst", lat, 17);
        check("arst_q", quotient, 30);
        check("arst_r", remainder, 10);

        // random nonzero divisors, mixing wide and small ranges
        for (int i = 0; i < 2000; i++) begin
            ra = W'($urandom);
            if (i % 2 == 0)
                rb = W'($urandom_range(1, 65535));
            else
                rb = W'($urandom_range(1, 300));
            issue(ra, rb);
            wait_done(lat);
            check("lat_rand", lat, 17);
        end

        @(negedge clk);
        check("scoreboard_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
